gcd_stein: RTL and testbench
============================

GCD_STEIN -- requirements
Module: gcd_stein

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (minimum 2).
REQ-002 SHALL have parameter CW, default $clog2(2*WIDTH+1)+1, width of the cycle-count output.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair is offered.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port a  input  WIDTH  first operand, unsigned.
REQ-008 SHALL have port b  input  WIDTH  second operand, unsigned.
REQ-009 SHALL have port out_valid  output  1  result is available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port result  output  WIDTH  gcd(a,b).
REQ-012 SHALL have port cycles  output  CW  number of RUN cycles used for this result.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-015 SHALL accept operands on a rising edge with in_valid && in_ready, registering a, b, k=0 and cycles=0.
REQ-016 SHALL go IDLE->DONE on acceptance when a==0 or b==0, with result=a|b (gcd(0,0)=0) and cycles=0; out_valid is then high in the next cycle.
REQ-017 SHALL otherwise go IDLE->RUN on acceptance.
REQ-018 SHALL, in each RUN cycle, increment cycles (saturating) and apply the first matching rule:
  - a==b: result=a<<k, go to DONE.
  - both even: a>>=1, b>>=1, k++.
  - a even: a>>=1.
  - b even: b>>=1.
  - both odd, a>b: a=(a-b)>>1.
  - both odd, a<b: b=(b-a)>>1.
REQ-019 SHALL keep all arithmetic unsigned WIDTH bits; a<<k never overflows because the result is at most min(a,b).
REQ-020 SHALL ignore changes on a, b and in_valid after acceptance until the block returns to IDLE.
REQ-021 SHALL hold result and cycles stable in DONE while out_ready=0, for any number of cycles.
REQ-022 SHALL go DONE->IDLE on the edge with out_ready=1; the next operand can be accepted no earlier than the following edge.
REQ-023 SHALL keep result and cycles at their last values while in IDLE.
REQ-024 SHALL bound RUN to at most 2*WIDTH cycles for any nonzero operands.

Reset
REQ-025 SHALL, while reset_n=0, immediately force state=IDLE, in_ready=1, out_valid=0, result=0, cycles=0, k=0 and internal a/b=0.
REQ-026 SHALL abort any RUN or DONE transaction on reset assertion, with no result delivered.
REQ-027 SHALL accept a new operand pair on the first rising edge after reset_n deasserts.

Structure
REQ-028 SHALL place the state enum and default WIDTH in shared package gcd_pkg.
REQ-029 SHALL place the one-step combinational datapath (parity tests, compare, subtract, shifts, equality flag) in sub-module gcd_step, instantiated once.
REQ-030 SHALL keep the state machine, registers and handshake logic in gcd_stein.

Verification
REQ-031 SHALL check: accept a=48, b=18 -> result=6, cycles=6, out_valid on the 6th edge after acceptance.
REQ-032 SHALL check: a=7, b=13 -> result=1, cycles=5; a=0, b=5 -> result=5, cycles=0; a=0, b=0 -> result=0, cycles=0.
REQ-033 SHALL check: WIDTH=8, a=128, b=1 -> result=1, cycles=8; a=255, b=255 -> result=255, cycles=1.
REQ-034 SHALL check: out_ready held low 10 cycles in DONE -> result stable, in_ready=0, and in_valid pulses with new operands are ignored.
REQ-035 SHALL check: reset_n pulsed low mid-RUN of 48,18 -> outputs at reset values immediately; then 7,13 -> result=1.
REQ-036 SHALL check: 1000 random pairs at WIDTH=16 compared against a reference model, with cycles<=32 and back-to-back handshakes.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the binary (Stein) GCD engine.
package gcd_pkg;

  localparam int GCD_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/gcd_step.sv
// One combinational Stein reduction step: picks the first matching rule for the
// current (a, b) pair and reports equality and whether the common-two count grows.
module gcd_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             eq_o,
  output logic             k_inc_o
);

  logic             a_even;
  logic             b_even;
  logic             a_gt_b;
  logic [WIDTH-1:0] a_minus_b;
  logic [WIDTH-1:0] b_minus_a;

  assign a_even    = ~a_i[0];
  assign b_even    = ~b_i[0];
  assign a_gt_b    = a_i > b_i;
  assign a_minus_b = a_i - b_i;
  assign b_minus_a = b_i - a_i;
  assign eq_o      = a_i == b_i;

  always_comb begin
    a_o     = a_i;
    b_o     = b_i;
    k_inc_o = 1'b0;
    if (!eq_o) begin
      if (a_even && b_even) begin
        a_o     = a_i >> 1;
        b_o     = b_i >> 1;
        k_inc_o = 1'b1;
      end else if (a_even) begin
        a_o = a_i >> 1;
      end else if (b_even) begin
        b_o = b_i >> 1;
      end else if (a_gt_b) begin
        // Difference of two odd values is even, so halving loses nothing.
        a_o = a_minus_b >> 1;
      end else begin
        b_o = b_minus_a >> 1;
      end
    end
  end

endmodule

// File: rtl/gcd_stein.sv
// Binary GCD engine: accepts an operand pair, applies one Stein rule per RUN cycle,
// and holds the result plus the RUN-cycle count until the consumer takes it.
module gcd_stein
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH_DEFAULT,
  parameter int CW    = $clog2(2*WIDTH+1)+1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    cycles
);

  localparam int KW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CYC_MAX = '1;

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cycles_q, cycles_d;

  logic [WIDTH-1:0] step_a;
  logic [WIDTH-1:0] step_b;
  logic             step_eq;
  logic             step_k_inc;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a_i     (a_q),
    .b_i     (b_q),
    .a_o     (step_a),
    .b_o     (step_b),
    .eq_o    (step_eq),
    .k_inc_o (step_k_inc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      result_q <= result_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    result_d = result_q;
    cycles_d = cycles_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          k_d      = '0;
          cycles_d = '0;
          // A zero operand makes the other one the answer (gcd(0,0) = 0).
          if (a == '0 || b == '0) begin
            result_d = a | b;
            state_d  = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (cycles_q != CYC_MAX) cycles_d = cycles_q + CW'(1);
        if (step_eq) begin
          result_d = a_q << k_q;
          state_d  = S_DONE;
        end else begin
          a_d = step_a;
          b_d = step_b;
          if (step_k_inc) k_d = k_q + KW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_gcd_stein.sv
// Self-checking bench for gcd_stein at WIDTH 32 (default), 8 and 16, with a
// Euclid-based reference model for randomized operand pairs.
module tb_gcd_stein;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        iv32, ir32, ov32, or32;
  logic [31:0] a32, b32, r32;
  logic [7:0]  c32;
  logic        iv8, ir8, ov8, or8;
  logic [7:0]  a8, b8, r8;
  logic [5:0]  c8;
  logic        iv16, ir16, ov16, or16;
  logic [15:0] a16, b16, r16;
  logic [6:0]  c16;

  int checks = 0;
  int errors = 0;

  gcd_stein u_dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .out_valid(ov32), .out_ready(or32), .result(r32), .cycles(c32)
  );

  gcd_stein #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .result(r8), .cycles(c8)
  );

  gcd_stein #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .out_valid(ov16), .out_ready(or16), .result(r16), .cycles(c16)
  );

  // Reference: Euclid by remainder, independent of the binary algorithm.
  function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic logic get_ir(input int w);
    case (w)
      8:       return ir8;
      16:      return ir16;
      default: return ir32;
    endcase
  endfunction

  function automatic logic get_ov(input int w);
    case (w)
      8:       return ov8;
      16:      return ov16;
      default: return ov32;
    endcase
  endfunction

  function automatic logic [31:0] get_res(input int w);
    case (w)
      8:       return {24'b0, r8};
      16:      return {16'b0, r16};
      default: return r32;
    endcase
  endfunction

  function automatic int get_cyc(input int w);
    case (w)
      8:       return int'(c8);
      16:      return int'(c16);
      default: return int'(c32);
    endcase
  endfunction

  task automatic drive(input int w, input logic v, input logic [31:0] av, input logic [31:0] bv);
    case (w)
      8:       begin iv8 = v;  a8 = av[7:0];   b8 = bv[7:0];   end
      16:      begin iv16 = v; a16 = av[15:0]; b16 = bv[15:0]; end
      default: begin iv32 = v; a32 = av;       b32 = bv;       end
    endcase
  endtask

  task automatic set_or(input int w, input logic v);
    case (w)
      8:       or8 = v;
      16:      or16 = v;
      default: or32 = v;
    endcase
  endtask

  // One full transaction; lat counts edges from acceptance until out_valid is seen.
  task automatic xact(input int w, input logic [31:0] av, input logic [31:0] bv,
                      output logic [31:0] res, output int cyc, output int lat);
    int n;
    n = 0;
    while (!get_ir(w) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!get_ir(w)) begin
      checks++; errors++;
      $display("FAIL accept_timeout w=%0d: in_ready=%b, required 1", w, get_ir(w));
    end
    drive(w, 1'b1, av, bv);
    @(posedge clk); #1;
    drive(w, 1'b0, ~av, ~bv);
    lat = 0;
    while (!get_ov(w) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!get_ov(w)) begin
      checks++; errors++;
      $display("FAIL done_timeout w=%0d a=%0d b=%0d: out_valid=%b, required 1", w, av, bv, get_ov(w));
    end
    res = get_res(w);
    cyc = get_cyc(w);
    set_or(w, 1'b1);
    @(posedge clk); #1;
    set_or(w, 1'b0);
  endtask

  task automatic test_reset();
    int ws[3];
    ws = '{8, 16, 32};
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(ws[i], 1'b0, 32'd0, 32'd0);
      set_or(ws[i], 1'b0);
    end
    #12;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (get_ir(ws[i]) !== 1'b1 || get_ov(ws[i]) !== 1'b0) begin
        errors++;
        $display("FAIL reset_handshake w=%0d: in_ready=%b out_valid=%b, required 1 0", ws[i], get_ir(ws[i]), get_ov(ws[i]));
      end
      checks++;
      if (get_res(ws[i]) !== 32'd0 || get_cyc(ws[i]) != 0) begin
        errors++;
        $display("FAIL reset_outputs w=%0d: result=%0d cycles=%0d, required 0 0", ws[i], get_res(ws[i]), get_cyc(ws[i]));
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] av[4], bv[4], er[4], res;
    int          ec[4];
    int          cyc, lat;
    av = '{32'd48, 32'd7,  32'd0, 32'd0};
    bv = '{32'd18, 32'd13, 32'd5, 32'd0};
    er = '{32'd6,  32'd1,  32'd5, 32'd0};
    ec = '{6, 5, 0, 0};
    for (int i = 0; i < 4; i++) begin
      xact(32, av[i], bv[i], res, cyc, lat);
      checks++;
      if (res !== er[i]) begin
        errors++;
        $display("FAIL basic_result a=%0d b=%0d: got %0d, required %0d", av[i], bv[i], res, er[i]);
      end
      checks++;
      if (cyc != ec[i] || lat != ec[i]) begin
        errors++;
        $display("FAIL basic_cycles a=%0d b=%0d: cycles=%0d latency=%0d, required %0d", av[i], bv[i], cyc, lat, ec[i]);
      end
    end
  endtask

  task automatic test_width8();
    logic [31:0] res;
    int          cyc, lat;
    xact(8, 32'd128, 32'd1, res, cyc, lat);
    checks++;
    if (res !== 32'd1 || cyc != 8) begin
      errors++;
      $display("FAIL w8_128_1: result=%0d cycles=%0d, required 1 8", res, cyc);
    end
    xact(8, 32'd255, 32'd255, res, cyc, lat);
    checks++;
    if (res !== 32'd255 || cyc != 1) begin
      errors++;
      $display("FAIL w8_255_255: result=%0d cycles=%0d, required 255 1", res, cyc);
    end
  endtask

  task automatic test_hold();
    int n;
    drive(32, 1'b1, 32'd48, 32'd18);
    @(posedge clk); #1;
    drive(32, 1'b0, 32'd0, 32'd0);
    n = 0;
    while (!ov32 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      drive(32, 1'b1, $urandom, $urandom);
      @(posedge clk); #1;
      checks++;
      if (r32 !== 32'd6 || c32 !== 8'd6 || ir32 !== 1'b0 || ov32 !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d: result=%0d cycles=%0d in_ready=%b out_valid=%b, required 6 6 0 1", i, r32, c32, ir32, ov32);
      end
    end
    drive(32, 1'b0, 32'd0, 32'd0);
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    checks++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0 || r32 !== 32'd6 || c32 !== 8'd6) begin
      errors++;
      $display("FAIL idle_keeps: in_ready=%b out_valid=%b result=%0d cycles=%0d, required 1 0 6 6", ir32, ov32, r32, c32);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] res;
    int          cyc, lat;
    drive(32, 1'b1, 32'd48, 32'd18);
    @(posedge clk); #1;
    drive(32, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0 || r32 !== 32'd0 || c32 !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_run: in_ready=%b out_valid=%b result=%0d cycles=%0d, required 1 0 0 0", ir32, ov32, r32, c32);
    end
    @(negedge clk);
    reset_n = 1'b1;
    xact(32, 32'd7, 32'd13, res, cyc, lat);
    checks++;
    if (res !== 32'd1 || cyc != 5) begin
      errors++;
      $display("FAIL after_reset_7_13: result=%0d cycles=%0d, required 1 5", res, cyc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av, bv, exp, res;
    int          cyc, lat, m, s;
    for (int i = 0; i < 1000; i++) begin
      m  = $urandom_range(0, 9);
      av = $urandom_range(0, 65535);
      bv = $urandom_range(0, 65535);
      if (m == 0) av = 32'd0;
      else if (m == 1) bv = 32'd0;
      else if (m == 2) bv = av;
      else if (m == 3) begin
        s  = $urandom_range(1, 8);
        av = (av >> s) << s;
        bv = (bv >> s) << s;
      end
      exp = ref_gcd(av, bv);
      xact(16, av, bv, res, cyc, lat);
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL rand_result a=%0d b=%0d: got %0d, required %0d", av, bv, res, exp);
      end
      checks++;
      if (cyc > 32 || cyc != lat) begin
        errors++;
        $display("FAIL rand_cycles a=%0d b=%0d: cycles=%0d latency=%0d, required equal and <=32", av, bv, cyc, lat);
      end
      checks++;
      if (ir16 !== 1'b1) begin
        errors++;
        $display("FAIL rand_ready_after_handshake a=%0d b=%0d: in_ready=%b, required 1", av, bv, ir16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_width8();
    test_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
